// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder used by the serial adder datapath.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  // Sum is the parity of the inputs; carry is their majority.
  always_comb begin
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one bit per clock, LSB first, through a
// single full-adder cell with a registered carry.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_c;

  full_adder_cell u_fa (
    .x (a_sr_q[0]),
    .y (b_sr_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  // Next-state logic: load on accepted start, shift one bit per SHIFT cycle,
  // publish the result on the last bit.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        s_sr_d  = WIDTH'({fa_s, s_sr_q} >> 1);
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = s_sr_d;
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB during the final bit.
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status flags decode directly from the registered state.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] msum, output logic mcout, output logic movf);
    logic [W:0] full;
    full  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    msum  = full[W-1:0];
    mcout = full[W];
    movf  = (ma[W-1] == mb[W-1]) && (msum[W-1] != ma[W-1]);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] esum,
                              input logic ecout, input logic eovf);
    check({name, "_sum"}, 32'(sum), 32'(esum));
    check({name, "_cout"}, 32'(cout), 32'(ecout));
`ifdef SERIAL_ADD_OVF_EN
    check({name, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: unexpected unknown overflow expectation");
`endif
  endtask

  // Issue one addition and wait (bounded) for done; reports latency and busy cycles.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        output int edges, output int busy_cyc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges    = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic finish_pulse(input string name);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1 check({name, "_done_drop"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int           e;
    int           bc;
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rci;

    checks   = 0;
    failures = 0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset then idle
    rst = 1'b1;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check_result("idle", 8'h00, 1'b0, 1'b0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, e, bc);
      check($sformatf("vec%0d_latency", i), 32'(e), 32'(W));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(W));
      check_result($sformatf("vec%0d", i), vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
      finish_pulse($sformatf("vec%0d", i));
    end

    // Start held high through SHIFT and DONE with new operands: ignored
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h11; b = 8'h22;
    e = 0;
    while (!done && e < 50) begin
      @(posedge clk);
      #1;
      e++;
      if (!done) check_result("held_midop", 8'h00, 1'b1, 1'b1);
    end
    check("held_latency", 32'(e), 32'(W));
    check_result("held", 8'h07, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    check("held_done_drop", 32'(done), 32'd0);
    check("held_no_requeue", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("held_idle", 32'(busy), 32'd0);
    check_result("held_after", 8'h07, 1'b0, 1'b0);
    do_add(8'h11, 8'h22, 1'b0, e, bc);
    check_result("second", 8'h33, 1'b0, 1'b0);
    finish_pulse("second");

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_result("midrst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midrst_idle", 32'(busy), 32'd0);
    do_add(8'h0F, 8'h0F, 1'b0, e, bc);
    check("postrst_latency", 32'(e), 32'(W));
    check_result("postrst", 8'h1E, 1'b0, 1'b0);
    finish_pulse("postrst");

    // Randomized against the arithmetic model
    for (int i = 0; i < 25; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rci = 1'($urandom);
      model(ra, rb, rci, rs, rc, ro);
      do_add(ra, rb, rci, e, bc);
      check($sformatf("rnd%0d_latency", i), 32'(e), 32'(W));
      check_result($sformatf("rnd%0d", i), rs, rc, ro);
      finish_pulse($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
